cpu_decode_stage: RTL and testbench
===================================

Name:
cpu_decode_stage

Overview:
Parametrised decode pipeline stage between fetch and execute, with valid/ready handshakes on both sides, a registered output slot, load-use hazard bubbling and branch flush. It decodes R/M/B instruction classes into a control packet, reads two register-file ports, sign-extends immediates to XLEN and flags illegal encodings.

Parameters:
XLEN, 32, data/PC width (>=32)
NUM_REGS, 32, architectural registers; REG_AW = $clog2(NUM_REGS), fields use low REG_AW bits of 5-bit slots
ZERO_REG_HARDWIRED, 1, register 0 never a hazard/bypass source and never written (reg_write forced 0 when dst==0)

Ports:
clock  in  1  clock
reset  in  1  reset, asynchronous, active-high
in_valid  in  1  fetch holds valid instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  32  instruction
in_next_pc  in  XLEN  PC+4 of instruction
flush  in  1  branch taken in execute; kill in-flight
rf_addr_a  out  REG_AW  read addr A = instr[19:15]
rf_addr_b  out  REG_AW  read addr B = instr[14:10]
rf_data_a  in  XLEN  async read data A
rf_data_b  in  XLEN  async read data B
wb_en  in  1  writeback write enable
wb_reg  in  REG_AW  writeback register
wb_data  in  XLEN  writeback data
out_valid  out  1  output slot valid
out_ready  in  1  execute accepts
out_ctrl  out  $bits(decode_ctrl_t)  packed control packet
out_ra_data  out  XLEN  operand A
out_rb_data  out  XLEN  operand B
out_offset  out  XLEN  sign-extended immediate
out_next_pc  out  XLEN  registered in_next_pc

Behaviour:
- Fields: class[31:29], func[28:25], dst[24:20], src1[19:15], src2[14:10]; M offset[14:0]; B offset = {instr[24:20], instr[9:0]} (15 bits). Sign-extend both to XLEN.
- Classes: R=3'b000 (func 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL; use_reg_b=1, reg_write=1); M=3'b001 (func 0 LDW, 1 LDB, 2 STW, 3 STB; alu_op=ADD, use_reg_b=0; loads set mem_read, mem_to_reg, reg_write; stores set mem_write, mem_byte for B forms); B=3'b010 (func 0 BEQ: alu_op=SUB, branch=1, use_reg_b=1, no writes). Any other class/func: illegal=1, all side-effect bits 0.
- Output slot states: EMPTY, FULL, BUBBLE. Accept = in_valid && in_ready. in_ready = !hazard && (state!=FULL || out_ready).
- Hazard (combinational): slot FULL, slot packet has mem_read, slot dst!=0, and slot dst equals incoming src1, or src2 for classes R/B. On hazard with out_ready: slot moves to BUBBLE (out_valid=0), fetch held. The next cycle proceeds normally.
- Transitions: EMPTY/BUBBLE→FULL on accept; FULL→FULL on accept&&out_ready; FULL→EMPTY on out_ready&&!accept; FULL holds all outputs while !out_ready. BUBBLE→EMPTY if no accept.
- flush (highest priority, synchronous): state→EMPTY, out_valid=0, in_ready=0 that cycle, incoming instruction dropped.
- Latency: 1 cycle accept→out_valid. Throughput 1/cycle without hazards.
- Reset: state EMPTY, out_valid=0, out_ctrl/out_*data/out_offset/out_next_pc=0. Reset mid-stall discards the slot.
- Simultaneous flush+hazard: flush wins. Simultaneous wb to src reg: see optional feature.

Optional Feature:
CPU_DECODE_WB_BYPASS_EN: when defined, on accept, if wb_en && wb_reg==src (nonzero), the captured operand is wb_data instead of rf_data. Without it, rf_data is captured unchanged; the register file must be write-first.

Decomposition:
cpu_decode_pkg: class/func constants, alu_op_t (2-bit ADD/SUB/AND/OR), decode_ctrl_t {ra_id, rb_id, reg_dest, alu_op, use_reg_b, is_mul, branch, mem_read, mem_write, mem_byte, mem_to_reg, reg_write, illegal}.
Sub-module cpu_decode_logic: pure combinational instr→decode_ctrl_t plus offset. The stage module holds the state machine, hazard and bypass logic.

Test Plan:
- Reset, then accept ADD r3,r1,r2 (rf 5,7) with out_ready=1 → next cycle out_valid=1, alu_op=ADD, reg_write=1, ra=5, rb=7, dest=3.
- LDW r4,-4(r1) then ADD r5,r4,r2 back-to-back → offset=0xFFFFFFFC, one bubble cycle (in_ready=0, out_valid=0), ADD emitted the cycle after.
- BEQ r1,r2 with offset bits 0x7FFF → offset sign-extends to all ones, branch=1, reg_write=0; out_ready=0 for 3 cycles → outputs stable, in_ready=0.
- flush asserted while slot FULL and in_valid=1 → out_valid=0 next cycle, instruction dropped, no hazard bubble produced.
- class 3'b111 → illegal=1, mem_write=0, reg_write=0; LD to r0 followed by use of r0 → no bubble.
- With CPU_DECODE_WB_BYPASS_EN: wb_en=1, wb_reg=1, wb_data=0xAB while decoding src1=r1 → out_ra_data=0xAB. Without the macro → rf_data_a is captured.

Source files
------------

// File: rtl/cpu_decode_pkg.sv
// Shared types for the decode stage: instruction class/func codes, ALU op and control packet.
package cpu_decode_pkg;

  localparam int unsigned RegFieldW = 5;

  localparam logic [2:0] ClassR = 3'b000;
  localparam logic [2:0] ClassM = 3'b001;
  localparam logic [2:0] ClassB = 3'b010;

  localparam logic [3:0] FuncAdd = 4'd0;
  localparam logic [3:0] FuncSub = 4'd1;
  localparam logic [3:0] FuncAnd = 4'd2;
  localparam logic [3:0] FuncOr  = 4'd3;
  localparam logic [3:0] FuncMul = 4'd4;

  localparam logic [3:0] FuncLdw = 4'd0;
  localparam logic [3:0] FuncLdb = 4'd1;
  localparam logic [3:0] FuncStw = 4'd2;
  localparam logic [3:0] FuncStb = 4'd3;

  localparam logic [3:0] FuncBeq = 4'd0;

  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluSub = 2'd1,
    AluAnd = 2'd2,
    AluOr  = 2'd3
  } alu_op_t;

  typedef struct packed {
    logic [RegFieldW-1:0] ra_id;
    logic [RegFieldW-1:0] rb_id;
    logic [RegFieldW-1:0] reg_dest;
    alu_op_t              alu_op;
    logic                 use_reg_b;
    logic                 is_mul;
    logic                 branch;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_byte;
    logic                 mem_to_reg;
    logic                 reg_write;
    logic                 illegal;
  } decode_ctrl_t;

  // Keep only the low aw bits of a 5-bit register slot.
  function automatic logic [RegFieldW-1:0] reg_field(input logic [RegFieldW-1:0] f,
                                                     input int unsigned aw);
    logic [RegFieldW-1:0] mask;
    mask = (RegFieldW'(1) << aw) - RegFieldW'(1);
    return f & mask;
  endfunction

endpackage

// File: rtl/cpu_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface cpu_decode_stage_if
  import cpu_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_next_pc;
  logic            flush;

  logic            out_valid;
  logic            out_ready;
  decode_ctrl_t    out_ctrl;
  logic [XLEN-1:0] out_ra_data;
  logic [XLEN-1:0] out_rb_data;
  logic [XLEN-1:0] out_offset;
  logic [XLEN-1:0] out_next_pc;

  // slave: the decode stage itself; master: the surrounding pipeline.
  modport slave (
    input  in_valid, in_instr, in_next_pc, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_ra_data, out_rb_data, out_offset, out_next_pc
  );

  modport master (
    output in_valid, in_instr, in_next_pc, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_ra_data, out_rb_data, out_offset, out_next_pc
  );
endinterface

// File: rtl/cpu_decode_logic.sv
// Pure combinational decoder: instruction word to control packet and sign-extended offset.
module cpu_decode_logic
  import cpu_decode_pkg::*;
#(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned NUM_REGS           = 32,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic [31:0]     instr_i,
  output decode_ctrl_t    ctrl_o,
  output logic [XLEN-1:0] offset_o
);
  localparam int unsigned RegAw = $clog2(NUM_REGS);

  logic [2:0]  cls;
  logic [3:0]  func;
  logic [14:0] m_off;
  logic [14:0] b_off;

  assign cls   = instr_i[31:29];
  assign func  = instr_i[28:25];
  assign m_off = instr_i[14:0];
  assign b_off = {instr_i[24:20], instr_i[9:0]};

  always_comb begin
    ctrl_o          = '0;
    ctrl_o.ra_id    = reg_field(instr_i[19:15], RegAw);
    ctrl_o.rb_id    = reg_field(instr_i[14:10], RegAw);
    ctrl_o.reg_dest = reg_field(instr_i[24:20], RegAw);
    case (cls)
      ClassR: begin
        case (func)
          FuncAdd: ctrl_o.alu_op = AluAdd;
          FuncSub: ctrl_o.alu_op = AluSub;
          FuncAnd: ctrl_o.alu_op = AluAnd;
          FuncOr:  ctrl_o.alu_op = AluOr;
          FuncMul: ctrl_o.is_mul = 1'b1;
          default: ctrl_o.illegal = 1'b1;
        endcase
        ctrl_o.use_reg_b = !ctrl_o.illegal;
        ctrl_o.reg_write = !ctrl_o.illegal;
      end
      ClassM: begin
        case (func)
          FuncLdw, FuncLdb: begin
            ctrl_o.mem_read   = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_byte   = (func == FuncLdb);
          end
          FuncStw, FuncStb: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.mem_byte  = (func == FuncStb);
          end
          default: ctrl_o.illegal = 1'b1;
        endcase
      end
      ClassB: begin
        if (func == FuncBeq) begin
          ctrl_o.alu_op    = AluSub;
          ctrl_o.branch    = 1'b1;
          ctrl_o.use_reg_b = 1'b1;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    if (ZERO_REG_HARDWIRED && (ctrl_o.reg_dest == '0)) begin
      ctrl_o.reg_write = 1'b0;
    end
  end

  always_comb begin
    offset_o = '0;
    case (cls)
      ClassM:  offset_o = {{(XLEN-15){m_off[14]}}, m_off};
      ClassB:  offset_o = {{(XLEN-15){b_off[14]}}, b_off};
      default: offset_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_decode_stage.sv
// Decode pipeline stage: registered output slot, load-use bubbling and branch flush.
// Optional macro CPU_DECODE_WB_BYPASS_EN forwards same-cycle writeback data into the operands.
module cpu_decode_stage
  import cpu_decode_pkg::*;
#(
  parameter int unsigned XLEN               = 32,
  parameter int unsigned NUM_REGS           = 32,
  parameter bit          ZERO_REG_HARDWIRED = 1'b1,
  localparam int unsigned REG_AW            = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  cpu_decode_stage_if.slave bus,
  output logic [REG_AW-1:0] rf_addr_a,
  output logic [REG_AW-1:0] rf_addr_b,
  input  logic [XLEN-1:0]   rf_data_a,
  input  logic [XLEN-1:0]   rf_data_b,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [XLEN-1:0]   wb_data
);
  localparam logic [1:0] StEmpty  = 2'd0;
  localparam logic [1:0] StFull   = 2'd1;
  localparam logic [1:0] StBubble = 2'd2;

  decode_ctrl_t    dec_ctrl;
  logic [XLEN-1:0] dec_offset;

  cpu_decode_logic #(
    .XLEN              (XLEN),
    .NUM_REGS          (NUM_REGS),
    .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED)
  ) u_decode_logic (
    .instr_i (bus.in_instr),
    .ctrl_o  (dec_ctrl),
    .offset_o(dec_offset)
  );

  logic [1:0]      state_q, state_d;
  decode_ctrl_t    ctrl_q, ctrl_d;
  logic [XLEN-1:0] ra_q, ra_d;
  logic [XLEN-1:0] rb_q, rb_d;
  logic [XLEN-1:0] offset_q, offset_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;

  logic [REG_AW-1:0] src1, src2, slot_dst;
  logic              in_uses_b, slot_load, hazard, accept;

  assign src1      = dec_ctrl.ra_id[REG_AW-1:0];
  assign src2      = dec_ctrl.rb_id[REG_AW-1:0];
  assign slot_dst  = ctrl_q.reg_dest[REG_AW-1:0];
  assign rf_addr_a = src1;
  assign rf_addr_b = src2;

  // A load still sitting in the slot cannot feed the instruction behind it.
  assign in_uses_b = (bus.in_instr[31:29] == ClassR) || (bus.in_instr[31:29] == ClassB);
  assign slot_load = (state_q == StFull) && ctrl_q.mem_read &&
                     (!ZERO_REG_HARDWIRED || (slot_dst != '0));
  assign hazard    = bus.in_valid && slot_load &&
                     ((slot_dst == src1) || (in_uses_b && (slot_dst == src2)));

  assign bus.in_ready = !bus.flush && !hazard && ((state_q != StFull) || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = StEmpty;
    end else if (accept) begin
      state_d = StFull;
    end else begin
      case (state_q)
        StFull:   if (bus.out_ready) state_d = hazard ? StBubble : StEmpty;
        StBubble: state_d = StEmpty;
        default:  state_d = StEmpty;
      endcase
    end
  end

  logic [XLEN-1:0] opnd_a, opnd_b;

`ifdef CPU_DECODE_WB_BYPASS_EN
  always_comb begin
    opnd_a = rf_data_a;
    opnd_b = rf_data_b;
    if (wb_en && (wb_reg != '0) && (wb_reg == src1)) opnd_a = wb_data;
    if (wb_en && (wb_reg != '0) && (wb_reg == src2)) opnd_b = wb_data;
  end
`else
  // Register file is write-first, so its read data already reflects writeback.
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_reg, wb_data};
  assign opnd_a    = rf_data_a;
  assign opnd_b    = rf_data_b;
`endif

  always_comb begin
    ctrl_d    = ctrl_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    offset_d  = offset_q;
    next_pc_d = next_pc_q;
    if (!bus.flush && accept) begin
      ctrl_d    = dec_ctrl;
      ra_d      = opnd_a;
      rb_d      = opnd_b;
      offset_d  = dec_offset;
      next_pc_d = bus.in_next_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StEmpty;
      ctrl_q    <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      offset_q  <= '0;
      next_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      offset_q  <= offset_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign bus.out_valid   = (state_q == StFull);
  assign bus.out_ctrl    = ctrl_q;
  assign bus.out_ra_data = ra_q;
  assign bus.out_rb_data = rb_q;
  assign bus.out_offset  = offset_q;
  assign bus.out_next_pc = next_pc_q;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Randomized bench for cpu_decode_stage against a transaction-level reference model.
module tb_cpu_decode_stage;
  import cpu_decode_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] rf [32];

  int n_cmp = 0;
  int n_bad = 0;

  cpu_decode_stage_if #(.XLEN(32)) bus ();

  cpu_decode_stage #(
    .XLEN              (32),
    .NUM_REGS          (32),
    .ZERO_REG_HARDWIRED(1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .rf_addr_a(rf_addr_a),
    .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a),
    .rf_data_b(rf_data_b),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data)
  );

  always #5 clock = ~clock;

  always_comb begin
    rf_data_a = rf[rf_addr_a];
    rf_data_b = rf[rf_addr_b];
  end

  // Reference model: one optional pending transaction in the output slot.
  logic         m_valid;
  decode_ctrl_t m_ctrl;
  logic [31:0]  m_ra, m_rb, m_off, m_npc;
  logic         seen_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic decode_ctrl_t ref_decode(input logic [31:0] ins);
    decode_ctrl_t c;
    int cls;
    int fn;
    cls = int'(ins[31:29]);
    fn  = int'(ins[28:25]);
    c = '0;
    c.ra_id    = ins[19:15];
    c.rb_id    = ins[14:10];
    c.reg_dest = ins[24:20];
    if (cls == 0 && fn <= 4) begin
      c.use_reg_b = 1'b1;
      c.reg_write = 1'b1;
      c.is_mul    = (fn == 4);
      c.alu_op    = (fn == 4) ? AluAdd : alu_op_t'(fn);
    end else if (cls == 1 && fn <= 3) begin
      c.mem_read   = (fn < 2);
      c.mem_to_reg = (fn < 2);
      c.reg_write  = (fn < 2);
      c.mem_write  = (fn >= 2);
      c.mem_byte   = (fn % 2 == 1);
    end else if (cls == 2 && fn == 0) begin
      c.alu_op    = AluSub;
      c.branch    = 1'b1;
      c.use_reg_b = 1'b1;
    end else begin
      c.illegal = 1'b1;
    end
    if (c.reg_dest == 5'd0) c.reg_write = 1'b0;
    return c;
  endfunction

  function automatic logic [31:0] sext15(input logic [14:0] v);
    return 32'(v) - (v >= 15'd16384 ? 32'h8000 : 32'h0);
  endfunction

  function automatic logic [31:0] ref_offset(input logic [31:0] ins);
    if (ins[31:29] == 3'b001) return sext15(ins[14:0]);
    if (ins[31:29] == 3'b010) return sext15({ins[24:20], ins[9:0]});
    return 32'h0;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] r, input logic we,
                                          input logic [4:0] wr, input logic [31:0] wd);
`ifdef CPU_DECODE_WB_BYPASS_EN
    if (we && wr == r && r != 5'd0) return wd;
`endif
    return rf[r];
  endfunction

  function automatic logic [31:0] enc(input int cls, input int fn, input int dst,
                                      input int s1, input logic [14:0] low);
    return {3'(cls), 4'(fn), 5'(dst), 5'(s1), low};
  endfunction

  // One cycle: entered and left at posedge+1.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] npc,
                      input logic fl, input logic ordy, input logic we, input logic [4:0] wr,
                      input logic [31:0] wd);
    logic hz, exp_rdy, src2_used;
    bus.in_valid   = iv;
    bus.in_instr   = ins;
    bus.in_next_pc = npc;
    bus.flush      = fl;
    bus.out_ready  = ordy;
    wb_en          = we;
    wb_reg         = wr;
    wb_data        = wd;
    #1;
    src2_used = (ins[31:29] == 3'b000) || (ins[31:29] == 3'b010);
    hz = m_valid && m_ctrl.mem_read && m_ctrl.reg_dest != 5'd0 &&
         (m_ctrl.reg_dest == ins[19:15] || (src2_used && m_ctrl.reg_dest == ins[14:10]));
    exp_rdy  = !fl && !hz && (!m_valid || ordy);
    seen_rdy = bus.in_ready;
    if (iv) begin
      check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      check("rf_addr_a", 64'(rf_addr_a), 64'(ins[19:15]));
    end
    @(posedge clock);
    if (fl) begin
      m_valid = 1'b0;
    end else if (iv && exp_rdy) begin
      m_valid = 1'b1;
      m_ctrl  = ref_decode(ins);
      m_ra    = operand(ins[19:15], we, wr, wd);
      m_rb    = operand(ins[14:10], we, wr, wd);
      m_off   = ref_offset(ins);
      m_npc   = npc;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    if (we && wr != 5'd0) rf[wr] = wd;
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      check("out_ctrl", 64'(bus.out_ctrl), 64'(m_ctrl));
      check("out_ra_data", 64'(bus.out_ra_data), 64'(m_ra));
      check("out_rb_data", 64'(bus.out_rb_data), 64'(m_rb));
      check("out_offset", 64'(bus.out_offset), 64'(m_off));
      check("out_next_pc", 64'(bus.out_next_pc), 64'(m_npc));
    end
  endtask

  task automatic idle_step(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0, 5'd0, 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int sel;
    ins = $urandom;
    sel = int'($urandom_range(0, 9));
    if (sel <= 3)      ins[31:25] = {3'b000, 4'($urandom_range(0, 5))};
    else if (sel <= 6) ins[31:25] = {3'b001, 4'($urandom_range(0, 4))};
    else if (sel <= 8) ins[31:25] = {3'b010, 4'($urandom_range(0, 1))};
    else               ins[31:29] = 3'($urandom_range(3, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[14:10] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    decode_ctrl_t zero_ctrl;
    logic [31:0]  ld_i, add_i;
    zero_ctrl = '0;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    m_valid = 1'b0;
    m_ctrl  = '0;
    {m_ra, m_rb, m_off, m_npc} = '0;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_instr   = '0;
    bus.in_next_pc = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    wb_en          = 1'b0;
    wb_reg         = '0;
    wb_data        = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_ctrl", 64'(bus.out_ctrl), 64'(zero_ctrl));
    check("rst_out_ra", 64'(bus.out_ra_data), 64'(0));
    check("rst_out_off", 64'(bus.out_offset), 64'(0));
    check("rst_out_npc", 64'(bus.out_next_pc), 64'(0));
    reset = 1'b0;

    // ADD r3,r1,r2
    step(1'b1, enc(0, 0, 3, 1, {5'd2, 10'd0}), 32'h104, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    check("add_valid", 64'(bus.out_valid), 64'(1));
    check("add_ra", 64'(bus.out_ra_data), 64'(5));
    check("add_rb", 64'(bus.out_rb_data), 64'(7));
    check("add_dest", 64'(bus.out_ctrl.reg_dest), 64'(3));
    check("add_wr", 64'(bus.out_ctrl.reg_write), 64'(1));

    // LDW r4,-4(r1) then ADD r5,r4,r2: one bubble
    ld_i  = enc(1, 0, 4, 1, 15'h7FFC);
    add_i = enc(0, 0, 5, 4, {5'd2, 10'd0});
    step(1'b1, ld_i, 32'h108, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    check("ldw_off", 64'(bus.out_offset), 64'(32'hFFFF_FFFC));
    step(1'b1, add_i, 32'h10C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    check("ld_use_rdy", 64'(seen_rdy), 64'(0));
    check("ld_use_bubble", 64'(bus.out_valid), 64'(0));
    step(1'b1, add_i, 32'h10C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    check("ld_use_emit", 64'(bus.out_valid), 64'(1));

    // BEQ r1,r2 with all-ones offset, then stall three cycles
    step(1'b1, {3'b010, 4'd0, 5'h1F, 5'd1, 5'd2, 10'h3FF}, 32'h110, 1'b0, 1'b1,
         1'b0, 5'd0, 32'h0);
    check("beq_off", 64'(bus.out_offset), 64'(32'hFFFF_FFFF));
    check("beq_branch", 64'(bus.out_ctrl.branch), 64'(1));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, add_i, 32'h114, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      check("stall_rdy", 64'(seen_rdy), 64'(0));
    end

    // Flush while full with a new instruction offered
    step(1'b1, ld_i, 32'h118, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    check("flush_rdy", 64'(seen_rdy), 64'(0));
    check("flush_valid", 64'(bus.out_valid), 64'(0));

    // Illegal class, then load to r0 followed by use of r0
    step(1'b1, enc(7, 0, 3, 1, 15'h0), 32'h11C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    check("ill_flag", 64'(bus.out_ctrl.illegal), 64'(1));
    check("ill_wr", 64'(bus.out_ctrl.reg_write), 64'(0));
    step(1'b1, enc(1, 0, 0, 1, 15'h4), 32'h120, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    step(1'b1, enc(0, 0, 6, 0, 15'h0), 32'h124, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    check("r0_no_bubble", 64'(seen_rdy), 64'(1));

    // Writeback to r1 while decoding src1=r1
    rf[1] = 32'd5;
    step(1'b1, enc(0, 0, 6, 1, {5'd2, 10'd0}), 32'h128, 1'b0, 1'b1, 1'b1, 5'd1, 32'hAB);
`ifdef CPU_DECODE_WB_BYPASS_EN
    check("wb_bypass", 64'(bus.out_ra_data), 64'(32'hAB));
`else
    check("wb_no_bypass", 64'(bus.out_ra_data), 64'(5));
`endif

    // Reset while stalled with a full slot
    step(1'b1, enc(0, 1, 7, 2, 15'h0), 32'h12C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    idle_step(1'b0);
    reset = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_ctrl", 64'(bus.out_ctrl), 64'(zero_ctrl));
    m_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;

    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 3) != 0), rand_instr(), $urandom, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
           $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
